// File: rtl/leve_axir_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leve_axir_arb_pkg
// Brief    : Shared arbiter state encoding and AXI burst-type constants.
// Revision : 1.0 - initial release
// ============================================================================
package leve_axir_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } leve_arb_st_t;

   // Burst encodings shared with the instruction burst buffer
   localparam logic [1:0] c_burst_fixed = 2'b00;
   localparam logic [1:0] c_burst_incr  = 2'b01;
   localparam logic [1:0] c_burst_wrap  = 2'b10;

   localparam int c_dcnt_w = 4;
   localparam int c_beat_w = 9;

endpackage
`default_nettype wire

// File: rtl/leve_axir_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : leve_axir_if
// Brief    : AXI read-channel (AR + R) bundle with initiator/target modports.
// Revision : 1.0 - initial release
// ============================================================================
interface leve_axir_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   import leve_axir_arb_pkg::*;

   logic              ARVALID;
   logic              ARREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [1:0]        ARBURST;
   logic [7:0]        ARLEN;
   logic              RVALID;
   logic              RREADY;
   logic [DATA_W-1:0] RDATA;
   logic              RLAST;

   modport master (
      output ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
      input  ARREADY, RVALID, RDATA, RLAST
   );

   modport slave (
      input  ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
      output ARREADY, RVALID, RDATA, RLAST
   );

endinterface
`default_nettype wire

// File: rtl/leve_axir_arb.sv
`default_nettype none
// ============================================================================
// Module   : leve_axir_arb
// Brief    : 2:1 AXI read arbiter (D over I, starvation guard, beat check).
// Revision : 1.0 - initial release
// ============================================================================
module leve_axir_arb
   import leve_axir_arb_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int MAX_D_CONSEC = 4
) (
   input  logic         CLK,
   input  logic         RSTn,
   leve_axir_if.slave   I_AXI,
   leve_axir_if.slave   D_AXI,
   leve_axir_if.master  M_AXI,
   output logic         GNT_D,
   output logic         BUSY,
   output logic         ERR
);

   localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(MAX_D_CONSEC);
   localparam logic [c_dcnt_w-1:0] c_dcnt_sat = '1;
   localparam logic [c_beat_w-1:0] c_beat_sat = '1;

   leve_arb_st_t        r_state;
   logic [c_dcnt_w-1:0] r_dcnt;
   logic [c_beat_w-1:0] r_beat;
   logic                r_gnt_d;
   logic                r_err;
   logic                r_m_arvalid;
   logic [ADDR_W-1:0]   r_m_araddr;
   logic [1:0]          r_m_arburst;
   logic [7:0]          r_m_arlen;

   logic                w_idle;
   logic                w_data;
   logic                w_starve;
   logic                w_gnt_d;
   logic                w_gnt_i;
   logic                w_rready;
   logic                w_beat;
   logic                w_len_err;
   logic [DATA_W-1:0]   w_rdata;

   assign w_idle   = (r_state == ARB_IDLE);
   assign w_data   = (r_state == ARB_DATA);

   // Once D has won MAX_D_CONSEC times in a row over a waiting I, I gets the next slot
   assign w_starve = I_AXI.ARVALID && (r_dcnt == c_dcnt_max);
   assign w_gnt_d  = w_idle && D_AXI.ARVALID && !w_starve;
   assign w_gnt_i  = w_idle && I_AXI.ARVALID && !w_gnt_d;

   assign I_AXI.ARREADY = w_gnt_i;
   assign D_AXI.ARREADY = w_gnt_d;

   assign w_rready  = w_data && (r_gnt_d ? D_AXI.RREADY : I_AXI.RREADY);
   assign w_beat    = w_rready && M_AXI.RVALID;
   assign w_rdata   = M_AXI.RDATA;

   // r_beat is the zero-based index of the beat currently on the bus
   assign w_len_err = M_AXI.RLAST ? (r_beat != {1'b0, r_m_arlen})
                                  : (r_beat >= {1'b0, r_m_arlen});

   assign I_AXI.RVALID = w_data && !r_gnt_d && M_AXI.RVALID;
   assign I_AXI.RLAST  = w_data && !r_gnt_d && M_AXI.RLAST;
   assign I_AXI.RDATA  = w_rdata;
   assign D_AXI.RVALID = w_data &&  r_gnt_d && M_AXI.RVALID;
   assign D_AXI.RLAST  = w_data &&  r_gnt_d && M_AXI.RLAST;
   assign D_AXI.RDATA  = w_rdata;

   assign M_AXI.ARVALID = r_m_arvalid;
   assign M_AXI.ARADDR  = r_m_araddr;
   assign M_AXI.ARBURST = r_m_arburst;
   assign M_AXI.ARLEN   = r_m_arlen;
   assign M_AXI.RREADY  = w_rready;

   assign GNT_D = r_gnt_d;
   assign ERR   = r_err;
   assign BUSY  = !w_idle;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= ARB_IDLE;
         r_dcnt      <= '0;
         r_beat      <= '0;
         r_gnt_d     <= 1'b0;
         r_err       <= 1'b0;
         r_m_arvalid <= 1'b0;
         r_m_araddr  <= '0;
         r_m_arburst <= '0;
         r_m_arlen   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_gnt_d || w_gnt_i) begin
                  r_m_araddr  <= w_gnt_d ? D_AXI.ARADDR  : I_AXI.ARADDR;
                  r_m_arburst <= w_gnt_d ? D_AXI.ARBURST : I_AXI.ARBURST;
                  r_m_arlen   <= w_gnt_d ? D_AXI.ARLEN   : I_AXI.ARLEN;
                  r_gnt_d     <= w_gnt_d;
                  r_m_arvalid <= 1'b1;
                  r_state     <= ARB_ADDR;
                  if (w_gnt_d && I_AXI.ARVALID) begin
                     if (r_dcnt != c_dcnt_sat)
                        r_dcnt <= r_dcnt + 1'b1;
                  end else begin
                     r_dcnt <= '0;
                  end
               end
            end
            ARB_ADDR: begin
               if (M_AXI.ARREADY) begin
                  r_m_arvalid <= 1'b0;
                  r_beat      <= '0;
                  r_state     <= ARB_DATA;
               end
            end
            ARB_DATA: begin
               if (w_beat) begin
                  if (r_beat != c_beat_sat)
                     r_beat <= r_beat + 1'b1;
                  if (w_len_err)
                     r_err <= 1'b1;
                  if (M_AXI.RLAST)
                     r_state <= ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_leve_axir_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_leve_axir_arb
// Brief    : Self-checking bench: vector table, R-data scoreboard, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leve_axir_arb;
   import leve_axir_arb_pkg::*;

   logic CLK;
   logic RSTn;
   logic GNT_D, BUSY, ERR;

   leve_axir_if #(.ADDR_W(64), .DATA_W(64)) I_AXI ();
   leve_axir_if #(.ADDR_W(64), .DATA_W(64)) D_AXI ();
   leve_axir_if #(.ADDR_W(64), .DATA_W(64)) M_AXI ();

   leve_axir_arb #(.ADDR_W(64), .DATA_W(64), .MAX_D_CONSEC(4)) dut (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .I_AXI (I_AXI.slave),
      .D_AXI (D_AXI.slave),
      .M_AXI (M_AXI.master),
      .GNT_D (GNT_D),
      .BUSY  (BUSY),
      .ERR   (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_d;
      logic [63:0] addr;
      logic [1:0]  burst;
      logic [7:0]  len;
      int          ar_dly;
      bit          rr_tog;
      bit          exp_gnt_d;
      bit          exp_err;
   } vec_t;

   int          n_chk;
   int          n_pass;
   logic [63:0] sb_q[$];
   vec_t        vecs[5];
   vec_t        vx;
   bit          got_d;
   bit          exp_ord[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [63:0] mkdata(input logic [63:0] a, input int b);
      return {a[31:0] ^ 32'hC0DE_0000, b[31:0]};
   endfunction

   task automatic run_txn(input vec_t v);
      logic [63:0] d, e;
      int          beat, cyc;
      logic        rr, shown, g_rv, g_rl, o_rv, o_rl;
      logic [63:0] g_rd, o_rd;
      d = '0;
      @(negedge CLK);
      if (v.is_d) begin
         D_AXI.ARVALID = 1'b1; D_AXI.ARADDR = v.addr; D_AXI.ARBURST = v.burst; D_AXI.ARLEN = v.len;
      end else begin
         I_AXI.ARVALID = 1'b1; I_AXI.ARADDR = v.addr; I_AXI.ARBURST = v.burst; I_AXI.ARLEN = v.len;
      end
      #1;
      chk("ar_ready_granted", v.is_d ? D_AXI.ARREADY : I_AXI.ARREADY, 1);
      chk("ar_ready_other",   v.is_d ? I_AXI.ARREADY : D_AXI.ARREADY, 0);
      @(negedge CLK);
      I_AXI.ARVALID = 1'b0;
      D_AXI.ARVALID = 1'b0;
      chk("m_arvalid", M_AXI.ARVALID, 1);
      chk("m_araddr",  M_AXI.ARADDR, v.addr);
      chk("m_arburst", M_AXI.ARBURST, v.burst);
      chk("m_arlen",   M_AXI.ARLEN, v.len);
      chk("gnt_d",     GNT_D, v.exp_gnt_d);
      chk("busy_addr", BUSY, 1);
      for (int k = 0; k < v.ar_dly; k++) begin
         if (v.is_d) I_AXI.ARVALID = 1'b1; else D_AXI.ARVALID = 1'b1;
         #1;
         chk("no_up_ready_addr", I_AXI.ARREADY | D_AXI.ARREADY, 0);
         chk("m_arvalid_hold",   M_AXI.ARVALID, 1);
         chk("m_araddr_hold",    M_AXI.ARADDR, v.addr);
         chk("m_arlen_hold",     M_AXI.ARLEN, v.len);
         @(negedge CLK);
      end
      I_AXI.ARVALID = 1'b0;
      D_AXI.ARVALID = 1'b0;
      M_AXI.ARREADY = 1'b1;
      @(negedge CLK);
      M_AXI.ARREADY = 1'b0;
      chk("m_arvalid_drop", M_AXI.ARVALID, 0);
      beat = 0; cyc = 0; rr = 1'b1; shown = 1'b0;
      while (beat <= int'(v.len) && cyc < 100) begin
         if (!shown) begin
            d = mkdata(v.addr, beat);
            M_AXI.RVALID = 1'b1;
            M_AXI.RDATA  = d;
            M_AXI.RLAST  = (beat == int'(v.len));
            sb_q.push_back(d);
            shown = 1'b1;
         end
         if (v.is_d) begin D_AXI.RREADY = rr; I_AXI.RREADY = !rr; end
         else        begin I_AXI.RREADY = rr; D_AXI.RREADY = !rr; end
         #1;
         g_rv = v.is_d ? D_AXI.RVALID : I_AXI.RVALID;
         g_rl = v.is_d ? D_AXI.RLAST  : I_AXI.RLAST;
         g_rd = v.is_d ? D_AXI.RDATA  : I_AXI.RDATA;
         o_rv = v.is_d ? I_AXI.RVALID : D_AXI.RVALID;
         o_rl = v.is_d ? I_AXI.RLAST  : D_AXI.RLAST;
         o_rd = v.is_d ? I_AXI.RDATA  : D_AXI.RDATA;
         chk("m_rready",       M_AXI.RREADY, rr);
         chk("rvalid_granted", g_rv, 1);
         chk("rvalid_other",   o_rv, 0);
         chk("rlast_other",    o_rl, 0);
         chk("rdata_other",    o_rd, d);
         if (rr) begin
            e = sb_q.pop_front();
            chk("rdata", g_rd, e);
            chk("rlast", g_rl, beat == int'(v.len));
            if (beat == int'(v.len)) chk("beat_cnt_at_last", dut.r_beat, v.len);
            beat++;
            shown = 1'b0;
         end
         @(negedge CLK);
         if (!shown) begin M_AXI.RVALID = 1'b0; M_AXI.RLAST = 1'b0; end
         cyc++;
         if (v.rr_tog) rr = !rr;
      end
      M_AXI.RVALID = 1'b0; M_AXI.RLAST = 1'b0;
      I_AXI.RREADY = 1'b0; D_AXI.RREADY = 1'b0;
      chk("beats_done", beat, int'(v.len) + 1);
      chk("busy_end",   BUSY, 0);
      chk("err",        ERR, v.exp_err);
   endtask

   task automatic issue_ar(input bit is_d, input logic [63:0] a, input logic [7:0] len);
      @(negedge CLK);
      if (is_d) begin D_AXI.ARVALID = 1'b1; D_AXI.ARADDR = a; D_AXI.ARLEN = len; D_AXI.ARBURST = c_burst_incr; end
      else      begin I_AXI.ARVALID = 1'b1; I_AXI.ARADDR = a; I_AXI.ARLEN = len; I_AXI.ARBURST = c_burst_incr; end
      @(negedge CLK);
      I_AXI.ARVALID = 1'b0; D_AXI.ARVALID = 1'b0;
      M_AXI.ARREADY = 1'b1;
      @(negedge CLK);
      M_AXI.ARREADY = 1'b0;
   endtask

   task automatic slave_beat(input bit last);
      M_AXI.RVALID = 1'b1; M_AXI.RLAST = last; M_AXI.RDATA = 64'hDEAD_0000 + 64'(n_chk);
      I_AXI.RREADY = 1'b1; D_AXI.RREADY = 1'b1;
      @(negedge CLK);
      M_AXI.RVALID = 1'b0; M_AXI.RLAST = 1'b0;
   endtask

   task automatic serve_one(output bit gd);
      int cyc;
      cyc = 0;
      #1;
      while (!I_AXI.ARREADY && !D_AXI.ARREADY && cyc < 20) begin
         @(negedge CLK); #1; cyc++;
      end
      chk("grant_seen", I_AXI.ARREADY | D_AXI.ARREADY, 1);
      chk("ready_onehot", I_AXI.ARREADY & D_AXI.ARREADY, 0);
      gd = D_AXI.ARREADY;
      @(negedge CLK);
      chk("arb_m_araddr", M_AXI.ARADDR, gd ? 64'hB000 : 64'hA000);
      chk("arb_gnt_d", GNT_D, gd);
      M_AXI.ARREADY = 1'b1;
      @(negedge CLK);
      M_AXI.ARREADY = 1'b0;
      M_AXI.RVALID = 1'b1; M_AXI.RLAST = 1'b1; M_AXI.RDATA = 64'h55;
      I_AXI.RREADY = 1'b1; D_AXI.RREADY = 1'b1;
      #1;
      chk("no_ready_at_rlast", I_AXI.ARREADY | D_AXI.ARREADY, 0);
      chk("arb_rvalid", gd ? D_AXI.RVALID : I_AXI.RVALID, 1);
      @(negedge CLK);
      M_AXI.RVALID = 1'b0; M_AXI.RLAST = 1'b0;
      chk("arb_busy_end", BUSY, 0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      RSTn = 1'b0;
      I_AXI.ARVALID = 0; I_AXI.ARADDR = 0; I_AXI.ARBURST = 0; I_AXI.ARLEN = 0; I_AXI.RREADY = 0;
      D_AXI.ARVALID = 0; D_AXI.ARADDR = 0; D_AXI.ARBURST = 0; D_AXI.ARLEN = 0; D_AXI.RREADY = 0;
      M_AXI.ARREADY = 0; M_AXI.RVALID = 0; M_AXI.RDATA = 0; M_AXI.RLAST = 0;

      vecs[0] = '{1'b0, 64'h1000, c_burst_incr,  8'd3, 0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 64'h2000, c_burst_incr,  8'd7, 5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 64'h3000, c_burst_incr,  8'd7, 0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 64'h4008, c_burst_wrap,  8'd1, 1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 64'h5000, c_burst_fixed, 8'd0, 2, 1'b0, 1'b0, 1'b0};
      exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      @(negedge CLK);
      chk("rst_m_arvalid", M_AXI.ARVALID, 0);
      chk("rst_m_araddr",  M_AXI.ARADDR, 0);
      chk("rst_m_arlen",   M_AXI.ARLEN, 0);
      chk("rst_m_arburst", M_AXI.ARBURST, 0);
      chk("rst_gnt_d",     GNT_D, 0);
      chk("rst_busy",      BUSY, 0);
      chk("rst_err",       ERR, 0);
      chk("rst_m_rready",  M_AXI.RREADY, 0);
      RSTn = 1'b1;

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // Early RLAST: beat index 2 of a 4-beat burst
      issue_ar(1'b0, 64'h6000, 8'd3);
      slave_beat(1'b0);
      slave_beat(1'b0);
      chk("err_before_early_last", ERR, 0);
      slave_beat(1'b1);
      chk("err_early_last", ERR, 1);
      chk("busy_after_early_last", BUSY, 0);
      vx = '{1'b0, 64'h7000, c_burst_incr, 8'd2, 0, 1'b0, 1'b0, 1'b1};
      run_txn(vx);

      // Asynchronous reset in the middle of a D burst
      issue_ar(1'b1, 64'h8000, 8'd3);
      slave_beat(1'b0);
      slave_beat(1'b0);
      chk("gnt_d_before_rst", GNT_D, 1);
      M_AXI.RVALID = 1'b1; D_AXI.RREADY = 1'b1;
      #2;
      RSTn = 1'b0;
      #1;
      chk("rst_mid_m_arvalid", M_AXI.ARVALID, 0);
      chk("rst_mid_m_rready",  M_AXI.RREADY, 0);
      chk("rst_mid_busy",      BUSY, 0);
      chk("rst_mid_err",       ERR, 0);
      chk("rst_mid_gnt_d",     GNT_D, 0);
      chk("rst_mid_d_rvalid",  D_AXI.RVALID, 0);
      chk("rst_mid_m_araddr",  M_AXI.ARADDR, 0);
      M_AXI.RVALID = 1'b0; D_AXI.RREADY = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      vx = '{1'b0, 64'h8800, c_burst_incr, 8'd1, 0, 1'b0, 1'b0, 1'b0};
      run_txn(vx);

      // Overrun: ARLEN=1 but slave sends three beats
      issue_ar(1'b1, 64'h9000, 8'd1);
      slave_beat(1'b0);
      chk("err_before_overrun", ERR, 0);
      slave_beat(1'b0);
      chk("err_overrun", ERR, 1);
      chk("busy_during_overrun", BUSY, 1);
      slave_beat(1'b1);
      chk("busy_after_overrun_last", BUSY, 0);

      // Starvation guard: both held valid continuously
      @(negedge CLK);
      I_AXI.ARADDR = 64'hA000; I_AXI.ARLEN = 8'd0; I_AXI.ARBURST = c_burst_incr;
      D_AXI.ARADDR = 64'hB000; D_AXI.ARLEN = 8'd0; D_AXI.ARBURST = c_burst_incr;
      I_AXI.ARVALID = 1'b1; D_AXI.ARVALID = 1'b1;
      for (int k = 0; k < 6; k++) begin
         serve_one(got_d);
         chk("grant_order", got_d, exp_ord[k]);
         if (k == 4) chk("dcnt_after_i", dut.r_dcnt, 0);
      end
      I_AXI.ARVALID = 1'b0; D_AXI.ARVALID = 1'b0;

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/leve_axir_arb.md
Name: leve_axir_arb

Overview:
- Two-to-one AXI read-channel arbiter that shares the single core read initiator between the instruction burst buffer (I port) and the future memory-access stage data loader (D port).
- Sits between the fetch/memory stages and the external AXIR initiator port.
- One outstanding transaction at a time.
- Fixed D-over-I priority with a starvation guard so that fetch always makes progress.
- Checks the burst beat count against the granted ARLEN.

Parameters:
- ADDR_W, 64, AR address width (XLEN).
- DATA_W, 64, R data width.
- MAX_D_CONSEC, 4, max consecutive D grants while I is waiting; range 1..15.

Ports:
- CLK  in  1  clock
- RSTn  in  1  async active-low reset
- I_ARVALID/I_ARREADY  in/out  1/1  instruction AR handshake
- I_ARADDR  in  ADDR_W  instruction address
- I_ARBURST  in  2  instruction burst type
- I_ARLEN  in  8  instruction beats-1
- I_RVALID/I_RREADY  out/in  1/1  instruction R handshake
- I_RDATA  out  DATA_W  instruction read data
- I_RLAST  out  1  instruction last beat
- D_ARVALID/D_ARREADY, D_ARADDR, D_ARBURST, D_ARLEN, D_RVALID/D_RREADY, D_RDATA, D_RLAST: same as I_*, for the data requester
- M_ARVALID  out  1  downstream AR valid
- M_ARREADY  in  1  downstream AR ready
- M_ARADDR  out  ADDR_W  downstream address
- M_ARBURST  out  2  downstream burst type
- M_ARLEN  out  8  downstream beats-1
- M_RVALID  in  1  downstream R valid
- M_RREADY  out  1  downstream R ready
- M_RDATA  in  DATA_W  downstream read data
- M_RLAST  in  1  downstream last beat
- GNT_D  out  1  current or last grant is D (debug)
- BUSY  out  1  state != IDLE
- ERR  out  1  sticky burst-length mismatch

Behaviour:
- Interface: reset RSTn, asynchronous, active-low; clock CLK. All state is on posedge CLK.
- Reset values:
  - State = IDLE.
  - M_ARVALID = 0; M_ARADDR, M_ARBURST, M_ARLEN = 0.
  - GNT_D = 0, ERR = 0, BUSY = 0.
  - D consecutive counter = 0, beat counter = 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Combinational arbitration. Grant D if D_ARVALID, unless I_ARVALID is set and dcnt == MAX_D_CONSEC; otherwise grant I if I_ARVALID.
  - The granted X_ARREADY = 1 in that same cycle only; the other ARREADY = 0.
  - On grant: register addr/burst/len into M_AR* and latch GNT_D, then go to ADDR.
  - Upstream ARREADY is 0 in every other state.
- dcnt update:
  - On a D grant while I_ARVALID is set: dcnt+1, saturating.
  - On an I grant, or on any D grant while I_ARVALID is clear: dcnt = 0.
- ADDR:
  - M_ARVALID = 1, with M_AR* stable.
  - On M_ARREADY, go to DATA and clear the beat counter.
  - Latency: upstream accept at cycle N, M_ARVALID at N+1, minimum.
- DATA:
  - M_RDATA, M_RLAST and M_RVALID are routed to the granted port. The non-granted port sees RVALID = 0, RLAST = 0, RDATA = M_RDATA.
  - M_RREADY = the granted port's RREADY; RREADY is 0 in IDLE and ADDR.
  - The beat counter increments on each M_RVALID & M_RREADY.
  - On a beat with M_RLAST: go to IDLE. A new grant is possible on the next cycle, so each transaction has at least one bubble.
  - ERR is set (sticky until reset) when RLAST arrives with beat count != M_ARLEN, or when the count passes M_ARLEN without RLAST.
  - On a count overrun the arbiter stays in DATA until RLAST.
- Simultaneous events:
  - Both valid in IDLE: D wins unless the starvation guard applies.
  - RLAST beat and a new request in the same cycle: the request waits for IDLE.
- Requester ARVALID drop before grant: allowed (no AXI stickiness enforced); arbitration uses current values.
- RSTn asserted mid-burst: everything returns to reset values immediately (async). The outstanding downstream burst is abandoned; system reset covers the slave.
- BUSY = (state != IDLE).

Decomposition:
- Shared package gets:
  - state enum leve_arb_st_t {ARB_IDLE, ARB_ADDR, ARB_DATA};
  - AXI burst constants (FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10), shared with the burst buffer.
- No sub-module: the FSM, the dcnt and beat counters, and the muxes fit in one module.

Test Plan:
- I-only request, addr 0x1000, INCR, len 3, M_ARREADY tied 1 -> I_ARREADY at cycle 0, M_ARVALID at cycle 1, 4 beats routed to I, last with I_RLAST, D_RVALID = 0 throughout, ERR = 0.
- I and D valid together in IDLE, MAX_D_CONSEC = 4 -> D granted first; D held valid continuously gives D,D,D,D,I grant order, then dcnt = 0.
- M_ARREADY delayed 5 cycles -> M_ARVALID held high with stable M_ARADDR = 0x2000 and M_ARLEN = 7 until accept; no upstream ARREADY meanwhile.
- Granted requester RREADY toggled 1/0 during an 8-beat burst -> M_RREADY mirrors it, no beats lost, beat counter = 7 at RLAST.
- Slave sends RLAST on beat 2 of len = 3 -> ERR rises on that cycle, FSM returns to IDLE, ERR stays 1 until reset.
- RSTn low during DATA beat 2 -> M_ARVALID = 0, M_RREADY = 0, BUSY = 0 immediately; after release an I request is granted normally.
